// File: rtl/sb_rx_packet_framer.sv
// Sideband RX packet framer.
// This block sits between the 64-bit deserializer and the sideband data decoder.
// It accepts assembled words and tracks whether the next word is a header or a payload.
// It checks control parity (CP) and data parity (DP), validates the opcode, and aborts
// a packet whose payload does not arrive in time. All outputs are registered.
//
// Ports:
//   i_clk                     sideband clock
//   i_rst_n                   asynchronous active-low reset
//   i_rx_enable               framer enable; low flushes to idle on the next edge
//   i_deser_valid             one-cycle pulse, i_deser_data holds a complete word
//   i_deser_data[63:0]        deserialized word
//   o_data[63:0]              registered copy of the last accepted word
//   o_header_is_valid_on_bus  pulse: o_data is a good header
//   o_data_enable             pulse: o_data is a good payload
//   o_header_has_data         level, updated with header strobe: header carries data
//   o_parity_error            pulse: CP or DP failure
//   o_opcode_error            pulse: unsupported opcode with good CP
//   o_timeout                 pulse: payload missing after TIMEOUT_CYCLES
module sb_rx_packet_framer #(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter logic [4:0]  OPC_MSG_NODATA = 5'b10010,
  parameter logic [4:0]  OPC_MSG_DATA   = 5'b11011
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx_enable,
  input  logic        i_deser_valid,
  input  logic [63:0] i_deser_data,
  output logic [63:0] o_data,
  output logic        o_header_is_valid_on_bus,
  output logic        o_data_enable,
  output logic        o_header_has_data,
  output logic        o_parity_error,
  output logic        o_opcode_error,
  output logic        o_timeout
);

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StWaitData = 2'd1;
  localparam logic [1:0] StDropData = 2'd2;

  // The last counter value before the timeout fires (TIMEOUT_CYCLES is limited to 2..65535).
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        dp_q, dp_d;
  logic [63:0] data_q, data_d;
  logic        hv_q, hv_d;
  logic        de_q, de_d;
  logic        hd_q, hd_d;
  logic        pe_q, pe_d;
  logic        oe_q, oe_d;
  logic        to_q, to_d;

  logic [4:0] opcode;
  logic       cp_ok;
  logic       dp_ok;

  assign opcode = i_deser_data[4:0];
  assign cp_ok  = ((^i_deser_data[61:0]) == i_deser_data[63]);
  assign dp_ok  = ((^i_deser_data) == dp_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dp_d    = dp_q;
    data_d  = data_q;
    hd_d    = hd_q;
    hv_d    = 1'b0;
    de_d    = 1'b0;
    pe_d    = 1'b0;
    oe_d    = 1'b0;
    to_d    = 1'b0;

    if (!i_rx_enable) begin
      state_d = StIdle;
      cnt_d   = 16'd0;
    end else begin
      if (i_deser_valid) begin
        data_d = i_deser_data;
      end
      case (state_q)
        StIdle: begin
          if (i_deser_valid) begin
            if (!cp_ok) begin
              pe_d = 1'b1;
              // A corrupted data header still occupies the link for one payload word.
              if (opcode == OPC_MSG_DATA) begin
                state_d = StDropData;
                cnt_d   = 16'd0;
              end
            end else if (opcode == OPC_MSG_NODATA) begin
              hv_d = 1'b1;
              hd_d = 1'b0;
            end else if (opcode == OPC_MSG_DATA) begin
              hv_d    = 1'b1;
              hd_d    = 1'b1;
              dp_d    = i_deser_data[62];
              cnt_d   = 16'd0;
              state_d = StWaitData;
            end else begin
              oe_d = 1'b1;
            end
          end
        end
        StWaitData, StDropData: begin
          // A word that arrives in the expiry cycle takes priority over the timeout.
          if (i_deser_valid) begin
            if (state_q == StWaitData) begin
              if (dp_ok) de_d = 1'b1;
              else       pe_d = 1'b1;
            end
            state_d = StIdle;
          end else if (cnt_q == TimeoutLast) begin
            to_d    = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = 16'd0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      dp_q    <= 1'b0;
      data_q  <= 64'd0;
      hv_q    <= 1'b0;
      de_q    <= 1'b0;
      hd_q    <= 1'b0;
      pe_q    <= 1'b0;
      oe_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dp_q    <= dp_d;
      data_q  <= data_d;
      hv_q    <= hv_d;
      de_q    <= de_d;
      hd_q    <= hd_d;
      pe_q    <= pe_d;
      oe_q    <= oe_d;
      to_q    <= to_d;
    end
  end

  assign o_data                   = data_q;
  assign o_header_is_valid_on_bus = hv_q;
  assign o_data_enable            = de_q;
  assign o_header_has_data        = hd_q;
  assign o_parity_error           = pe_q;
  assign o_opcode_error           = oe_q;
  assign o_timeout                = to_q;

endmodule

// File: tb/tb_sb_rx_packet_framer.sv
// Directed bench for sb_rx_packet_framer (TIMEOUT_CYCLES = 4).
// Inputs are driven and outputs sampled on the falling clock edge.
// Flags are compared as {hdr_valid, data_en, has_data, parity_err, opcode_err, timeout}.
module tb_sb_rx_packet_framer;

  logic        clk;
  logic        rst_n;
  logic        rx_enable;
  logic        deser_valid;
  logic [63:0] deser_data;
  logic [63:0] data;
  logic        hdr_valid;
  logic        data_en;
  logic        has_data;
  logic        parity_err;
  logic        opcode_err;
  logic        timeout;

  int tests_run = 0;
  int tests_failed = 0;

  sb_rx_packet_framer #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .i_clk                    (clk),
    .i_rst_n                  (rst_n),
    .i_rx_enable              (rx_enable),
    .i_deser_valid            (deser_valid),
    .i_deser_data             (deser_data),
    .o_data                   (data),
    .o_header_is_valid_on_bus (hdr_valid),
    .o_data_enable            (data_en),
    .o_header_has_data        (has_data),
    .o_parity_error           (parity_err),
    .o_opcode_error           (opcode_err),
    .o_timeout                (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Header with opcode, MsgCode at [21:14], DP at [62] and a correct CP at [63].
  function automatic logic [63:0] mk_hdr(input logic [4:0] opc, input logic [7:0] msg,
                                         input logic dp);
    logic [63:0] w;
    w        = 64'd0;
    w[4:0]   = opc;
    w[21:14] = msg;
    w[62]    = dp;
    w[63]    = ^w[61:0];
    return w;
  endfunction

  // Present one input cycle; returns after the accepting edge, at the next falling edge.
  task automatic cyc(input logic v, input logic [63:0] d);
    deser_valid = v;
    deser_data  = d;
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [5:0] exp_flags, input logic [63:0] exp_data);
    logic [5:0] flags;
    flags = {hdr_valid, data_en, has_data, parity_err, opcode_err, timeout};
    tests_run++;
    assert (flags === exp_flags) else begin
      tests_failed++;
      $error("FAIL %s flags: got %b expected %b", tag, flags, exp_flags);
    end
    tests_run++;
    assert (data === exp_data) else begin
      tests_failed++;
      $error("FAIL %s data: got %h expected %h", tag, data, exp_data);
    end
  endtask

  logic [63:0] h_nodata;
  logic [63:0] h_data;
  logic [63:0] h_bad;
  logic [63:0] h_badopc;
  logic [63:0] junk;

  initial begin
    h_nodata = mk_hdr(5'b10010, 8'hA5, 1'b0);
    h_data   = mk_hdr(5'b11011, 8'h3C, 1'b1);
    h_bad    = h_data ^ {1'b1, 63'd0};
    h_badopc = mk_hdr(5'b00001, 8'h00, 1'b0);
    junk     = 64'hDEAD_BEEF_0000_1234;

    rst_n       = 1'b0;
    rx_enable   = 1'b1;
    deser_valid = 1'b0;
    deser_data  = 64'd0;
    @(negedge clk);
    @(negedge clk);
    chk("reset", 6'b000000, 64'd0);
    rst_n = 1'b1;
    cyc(1'b0, 64'd0);
    chk("post_reset_idle", 6'b000000, 64'd0);

    // No-data header, then hold.
    cyc(1'b1, h_nodata);
    chk("nodata_hdr", 6'b100000, h_nodata);
    cyc(1'b0, 64'd0);
    chk("nodata_hold", 6'b000000, h_nodata);

    // Data message with payload three cycles later, good DP.
    cyc(1'b1, h_data);
    chk("data_hdr", 6'b101000, h_data);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b0, 64'd0);
      chk("data_wait", 6'b001000, h_data);
    end
    cyc(1'b1, 64'h1);
    chk("data_payload_ok", 6'b011000, 64'h1);

    // Bad DP.
    cyc(1'b1, h_data);
    chk("dp_hdr", 6'b101000, h_data);
    cyc(1'b1, 64'h3);
    chk("dp_bad", 6'b001100, 64'h3);

    // Bad CP on a data header: the next word is dropped, the one after is a header.
    cyc(1'b1, h_bad);
    chk("cp_bad", 6'b001100, h_bad);
    cyc(1'b1, junk);
    chk("cp_drop", 6'b001000, junk);
    cyc(1'b1, h_nodata);
    chk("cp_after_drop", 6'b100000, h_nodata);

    // Timeout in WAIT_DATA.
    cyc(1'b1, h_data);
    chk("to_hdr", 6'b101000, h_data);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 64'd0);
      chk("to_wait", 6'b001000, h_data);
    end
    cyc(1'b0, 64'd0);
    chk("to_fire", 6'b001001, h_data);
    cyc(1'b0, 64'd0);
    chk("to_pulse_end", 6'b001000, h_data);

    // Payload in the expiry cycle wins over the timeout.
    cyc(1'b1, h_data);
    chk("to_race_hdr", 6'b101000, h_data);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 64'd0);
      chk("to_race_wait", 6'b001000, h_data);
    end
    cyc(1'b1, 64'h1);
    chk("to_race_payload", 6'b011000, 64'h1);

    // Unsupported opcode with good CP.
    cyc(1'b1, h_badopc);
    chk("opcode_err", 6'b001010, h_badopc);

    // Back-to-back header and payload.
    cyc(1'b1, h_data);
    chk("b2b_hdr", 6'b101000, h_data);
    cyc(1'b1, 64'h1);
    chk("b2b_payload", 6'b011000, 64'h1);
    cyc(1'b1, h_nodata);
    chk("b2b_nodata1", 6'b100000, h_nodata);
    cyc(1'b1, h_nodata);
    chk("b2b_nodata2", 6'b100000, h_nodata);

    // Timeout in DROP_DATA.
    cyc(1'b1, h_bad);
    chk("drop_to_hdr", 6'b000100, h_bad);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 64'd0);
      chk("drop_to_wait", 6'b000000, h_bad);
    end
    cyc(1'b0, 64'd0);
    chk("drop_to_fire", 6'b000001, h_bad);

    // Enable dropped in WAIT_DATA: payload ignored, framer back in idle.
    cyc(1'b1, h_data);
    chk("en_hdr", 6'b101000, h_data);
    rx_enable = 1'b0;
    cyc(1'b1, 64'h1);
    chk("en_low_payload", 6'b001000, h_data);
    rx_enable = 1'b1;
    cyc(1'b1, h_nodata);
    chk("en_back_idle", 6'b100000, h_nodata);

    // Asynchronous reset mid-packet.
    cyc(1'b1, h_data);
    chk("rst_hdr", 6'b101000, h_data);
    deser_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk("rst_async", 6'b000000, 64'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b1, h_nodata);
    chk("rst_next_is_hdr", 6'b100000, h_nodata);
    cyc(1'b0, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
